// File: rtl/cosim_commit_sequencer.sv
// cosim_commit_sequencer: buffers per-hart retire records and serialises them round-robin onto one checker port
// Ports:
//   clock, reset (async, active-low)
//   in_valid/in_pc/in_insn : per-hart retire slots, index h*COMMITS+s, slot 0 oldest
//   in_ready               : hart h may present a commit group this cycle
//   out_valid/out_ready    : record handshake towards the commit checker
//   out_hart/out_pc/out_insn : presented record, zero when idle
//   flush                  : synchronous discard of all buffered records
//   overflow               : sticky, a group was dropped while its hart was not ready
//   busy                   : any FIFO non-empty
module cosim_commit_sequencer #(
    parameter int HARTS = 1,
    parameter int COMMITS = 2,
    parameter int DEPTH = 8,
    parameter int XLEN = 64,
    localparam int HID_W = (HARTS > 1) ? $clog2(HARTS) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [HARTS*COMMITS-1:0]      in_valid,
    input  logic [HARTS*COMMITS*XLEN-1:0] in_pc,
    input  logic [HARTS*COMMITS*32-1:0]   in_insn,
    output logic [HARTS-1:0]              in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [HID_W-1:0]              out_hart,
    output logic [XLEN-1:0]               out_pc,
    output logic [31:0]                   out_insn,
    input  logic                          flush,
    output logic                          overflow,
    output logic                          busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [HARTS-1:0][CW-1:0] count, push_n;
    logic [HARTS-1:0][AW-1:0] wr_ptr, rd_ptr;
    logic [HARTS-1:0][COMMITS-1:0][AW-1:0] off;
    logic [HARTS-1:0] nonempty, has_grp, push_en, pop_en;
    logic [HID_W-1:0] rr_ptr, grant, grant_nx;
    logic [XLEN-1:0] pc_mem [HARTS][DEPTH];
    logic [31:0] insn_mem [HARTS][DEPTH];
    for (genvar h = 0; h < HARTS; h++) begin : g_hart
        assign in_ready[h] = count[h] <= CW'(DEPTH - COMMITS);
        assign nonempty[h] = count[h] != '0;
        assign has_grp[h] = |in_valid[h*COMMITS +: COMMITS];
        assign push_en[h] = in_ready[h] && has_grp[h];
        assign pop_en[h] = out_valid && out_ready && grant == HID_W'(h);
    end
    // Compaction: each valid slot lands at wr_ptr + number of valid slots below it.
    always_comb begin
        push_n = '0;
        off = '0;
        for (int i = 0; i < HARTS; i++) begin
            for (int s = 0; s < COMMITS; s++) begin
                off[i][s] = AW'(push_n[i]);
                push_n[i] = push_n[i] + CW'(in_valid[i*COMMITS+s]);
            end
        end
    end
    // First non-empty hart at or after rr_ptr; descending scan so the nearest wins.
    always_comb begin
        grant = rr_ptr;
        for (int i = HARTS - 1; i >= 0; i--) begin
            if (nonempty[(int'(rr_ptr) + i) % HARTS]) grant = HID_W'((int'(rr_ptr) + i) % HARTS);
        end
        grant_nx = HID_W'((int'(grant) + 1) % HARTS);
    end
    assign out_valid = |nonempty;
    assign busy = out_valid;
    assign out_hart = out_valid ? grant : '0;
    assign out_pc = out_valid ? pc_mem[grant][rd_ptr[grant]] : '0;
    assign out_insn = out_valid ? insn_mem[grant][rd_ptr[grant]] : '0;
    always_ff @(posedge clock) begin
        for (int i = 0; i < HARTS; i++) begin
            for (int s = 0; s < COMMITS; s++) begin
                if (push_en[i] && in_valid[i*COMMITS+s]) begin
                    pc_mem[i][wr_ptr[i] + off[i][s]] <= in_pc[(i*COMMITS+s)*XLEN +: XLEN];
                    insn_mem[i][wr_ptr[i] + off[i][s]] <= in_insn[(i*COMMITS+s)*32 +: 32];
                end
            end
        end
    end
    // On a stall rr_ptr parks on the grant, so a late push to an earlier hart cannot steal it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr_ptr <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= overflow | (|(has_grp & ~in_ready));
            if (flush) begin
                count <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                rr_ptr <= '0;
            end else begin
                for (int i = 0; i < HARTS; i++) begin
                    count[i] <= count[i] + (push_en[i] ? push_n[i] : '0) - CW'(pop_en[i]);
                    wr_ptr[i] <= wr_ptr[i] + (push_en[i] ? AW'(push_n[i]) : '0);
                    rd_ptr[i] <= rd_ptr[i] + AW'(pop_en[i]);
                end
                if (out_valid) rr_ptr <= out_ready ? grant_nx : grant;
            end
        end
    end
endmodule
